// File: rtl/bus_arbiter_2way_pkg.sv
// Shared definitions for the bus arbiters: FSM state encodings and default
// watchdog sizing, kept here so a future N-way arbiter can reuse them.
package bus_arbiter_2way_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT1 = 2'd1,
        ST_GNT2 = 2'd2
    } arb_state_e;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 16;
    localparam int unsigned ARB_CNTW_DEFAULT    = 5;

endpackage : bus_arbiter_2way_pkg

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts grant cycles and flags the last permitted one.
// TIMEOUT of 0 disables expiry; 2**CNTW must exceed TIMEOUT.
module arb_watchdog
    import bus_arbiter_2way_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int unsigned CNTW    = ARB_CNTW_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNTW-1:0] TC_VAL = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == TC_VAL);

endmodule : arb_watchdog

// File: rtl/bus_arbiter_2way.sv
// Two-master round-robin bus arbiter: holds the grant for a whole transaction,
// inserts one idle cycle between transactions and aborts a stuck slave.
module bus_arbiter_2way
    import bus_arbiter_2way_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int unsigned CNTW    = ARB_CNTW_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic slaveDone,
    output logic sel,
    output logic gnt1,
    output logic gnt2,
    output logic slaveReq,
    output logic busy,
    output logic timeoutErr
);

    arb_state_e state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_grant_q, last_grant_d;   // 0: master1 served last, 1: master2
    logic       timeout_err_q, timeout_err_d;
    logic       hold;
    logic       wd_expired;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (~hold),
        .en      (hold),
        .expired (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_grant_d  = last_grant_q;
        timeout_err_d = 1'b0;
        hold          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // On a tie the master that was not served last wins.
                if (req1 && (!req2 || last_grant_q)) begin
                    state_d = ST_GNT1;
                    sel_d   = 1'b0;
                end else if (req2) begin
                    state_d = ST_GNT2;
                    sel_d   = 1'b1;
                end
            end
            ST_GNT1: begin
                if (slaveDone || !req1 || wd_expired) begin
                    state_d       = ST_IDLE;
                    last_grant_d  = 1'b0;
                    timeout_err_d = !slaveDone && req1;
                end else begin
                    hold = 1'b1;
                end
            end
            ST_GNT2: begin
                if (slaveDone || !req2 || wd_expired) begin
                    state_d       = ST_IDLE;
                    last_grant_d  = 1'b1;
                    timeout_err_d = !slaveDone && req2;
                end else begin
                    hold = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_grant_q  <= last_grant_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt1       = (state_q == ST_GNT1);
    assign gnt2       = (state_q == ST_GNT2);
    assign busy       = (state_q != ST_IDLE);
    assign sel        = sel_q;
    assign timeoutErr = timeout_err_q;
    assign slaveReq   = (gnt1 & req1) | (gnt2 & req2);

endmodule : bus_arbiter_2way

// File: tb/tb_bus_arbiter_2way.sv
// Self-checking bench for bus_arbiter_2way: directed scenarios plus random
// traffic, all compared against a transaction-level ownership model.
module tb_bus_arbiter_2way;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    logic req1, req2, slave_done;
    logic sel, gnt1, gnt2, slave_req, busy, timeout_err;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the slave and for how many cycles so far.
    int m_owner;   // 0 none, 1 master1, 2 master2
    int m_age;     // completed grant cycles of the current owner
    int m_last;    // master served most recently
    bit m_sel;
    bit m_err;

    bus_arbiter_2way #(
        .TIMEOUT (TO),
        .CNTW    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req1       (req1),
        .req2       (req2),
        .slaveDone  (slave_done),
        .sel        (sel),
        .gnt1       (gnt1),
        .gnt2       (gnt2),
        .slaveReq   (slave_req),
        .busy       (busy),
        .timeoutErr (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running, want done");
        $fatal(1, "bench time limit expired");
    end

    task automatic model_reset();
        m_owner = 0;
        m_age   = 0;
        m_last  = 2;
        m_sel   = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the transaction rules, given the inputs seen at that edge.
    task automatic model_edge(input bit r1, input bit r2, input bit d);
        m_err = 1'b0;
        if (m_owner == 0) begin
            if (r1 && r2)  m_owner = (m_last == 1) ? 2 : 1;
            else if (r1)   m_owner = 1;
            else if (r2)   m_owner = 2;
            if (m_owner != 0) begin
                m_sel = (m_owner == 2);
                m_age = 0;
            end
        end else begin
            bit still_wants;
            still_wants = (m_owner == 1) ? r1 : r2;
            if (d || !still_wants) begin
                m_last  = m_owner;
                m_owner = 0;
            end else if (TO != 0 && m_age + 1 == TO) begin
                m_err   = 1'b1;
                m_last  = m_owner;
                m_owner = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    function automatic logic [5:0] exp_vec();
        bit sreq;
        sreq = (m_owner == 1 && req1) || (m_owner == 2 && req2);
        return {m_owner == 1, m_owner == 2, m_sel, m_owner != 0, sreq, m_err};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {gnt1, gnt2, sel, busy, slave_req, timeout_err};
    endfunction

    // Drive one cycle of inputs, step the model, and land 1 time unit after the edge.
    task automatic cyc(input bit r1, input bit r2, input bit d);
        req1       = r1;
        req2       = r2;
        slave_done = d;
        model_edge(r1, r2, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req1 = 1'b0; req2 = 1'b0; slave_done = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== 6'b0) begin
            bad++;
            $display("FAIL reset_state: got %b want %b", obs_vec(), 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_pre_grant1: got %b want %b", obs_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({gnt1, sel, busy, slave_req, timeout_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_midgrant: got gnt1/sel/busy/sreq/err=%b want 00000",
                     {gnt1, sel, busy, slave_req, timeout_err});
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1, 0);
        total++;
        if (gnt2 !== 1'b1 || sel !== 1'b1 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_then_req2: got gnt2=%b sel=%b gnt1=%b want 1 1 0", gnt2, sel, gnt1);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_contention();
        int order[$];
        bit prev_busy;
        prev_busy = busy;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, (m_owner != 0 && m_age == 2));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL contention_cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (busy && !prev_busy) order.push_back(gnt2 ? 2 : 1);
            prev_busy = busy;
        end
        total++;
        if (order.size() != 4 || order[0] != 1 || order[1] != 2 || order[2] != 1 || order[3] != 2) begin
            bad++;
            $display("FAIL contention_order: got %p want 1,2,1,2", order);
        end
    endtask

    task automatic test_single_master();
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, (m_owner != 0 && m_age == 1));
            total++;
            if (gnt1 !== (i % 3 != 2) || sel !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL single_cyc%0d: got gnt1=%b sel=%b vec=%b want gnt1=%b sel=0 vec=%b",
                         i, gnt1, sel, obs_vec(), (i % 3 != 2), exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        int gnt2_cycles = 0;
        int err_pulses  = 0;
        bit gnt1_after  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(i >= 2, 1, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL timeout_cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (gnt2) gnt2_cycles++;
            if (timeout_err) err_pulses++;
            if (i == 5) gnt1_after = gnt1;
        end
        total++;
        if (gnt2_cycles != TO || err_pulses != 1 || !gnt1_after) begin
            bad++;
            $display("FAIL timeout_abort: got gnt2_cycles=%0d err_pulses=%0d gnt1_next=%b want %0d 1 1",
                     gnt2_cycles, err_pulses, gnt1_after, TO);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_corners();
        // Completion on the last permitted cycle is not an error.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, (m_owner == 1 && m_age == TO - 1));
            total++;
            if (timeout_err !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL done_at_expiry_cyc%0d: got %b want %b err=0", i, obs_vec(), exp_vec());
            end
        end
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        total++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL withdraw: got busy=%b err=%b gnt1=%b want 0 0 0", busy, timeout_err, gnt1);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1);
            total++;
            if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
                bad++;
                $display("FAIL done_in_idle_%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
            total++;
            if (obs_vec() !== exp_vec() || (gnt1 && gnt2)) begin
                bad++;
                $display("FAIL random_cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_master();
        test_timeout();
        test_corners();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_arbiter_2way
